// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings, owner codes and grant policy
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam int   CNT_W  = 4;

  // Data wins a tie unless it was served last, so a fetch always follows a data access.
  function automatic logic pick_data(input logic if_req, input logic d_req,
                                     input logic last_data);
    return d_req & (~if_req | ~last_data);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - 4-bit loadable down-counter with zero flag
module mem_wait_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and MEM stage
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [DW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [DW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_stall,
  output logic          d_stall
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t           state, next_state;
  logic             owner;
  logic             is_write;
  logic             last_data;
  logic             grant;
  logic             grant_data;
  logic             busy;
  logic             done_access;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic             d_req;

  assign d_req       = d_read | d_write;
  assign busy        = (state == ST_BUSY);
  assign done_access = busy & cnt_zero;

  mem_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .load_val (CNT_INIT),
    .dec      (busy),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_data = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (if_req | d_req) begin
          grant      = 1'b1;
          grant_data = pick_data(if_req, d_req, last_data);
          next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_IF;
      is_write  <= 1'b0;
      last_data <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grant) begin
        owner     <= grant_data ? OWN_D : OWN_IF;
        is_write  <= grant_data & d_write;
        mem_en    <= 1'b1;
        mem_we    <= grant_data & d_write;
        mem_addr  <= grant_data ? d_addr : if_addr;
        mem_wdata <= grant_data ? d_wdata : '0;
      end
      // Address and write data stay on the port after completion; only the enables drop.
      if (done_access) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (owner == OWN_D) begin
          d_ready <= 1'b1;
          if (!is_write) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
      if (state == ST_DONE) begin
        last_data <= owner;
      end
    end
  end

  assign if_stall = if_req & ~if_ready;
  assign d_stall  = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_read, d_write;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic        if_ready_a, d_ready_a, mem_en_a, mem_we_a, if_stall_a, d_stall_a;
  logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        if_ready_b, d_ready_b, mem_en_b, mem_we_b, if_stall_b, d_stall_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        if_ready_c, d_ready_c, mem_en_c, mem_we_c, if_stall_c, d_stall_c;
  logic [31:0] if_rdata_c, d_rdata_c, mem_addr_c, mem_wdata_c, mem_rdata_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C01_0004 : (a ^ 32'hA5A5_0000);
  endfunction

  assign mem_rdata_a = mem_model(mem_addr_a);
  assign mem_rdata_b = mem_model(mem_addr_b);
  assign mem_rdata_c = mem_model(mem_addr_c);

  mem_port_arbiter #(.DW(32), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready_a),
    .if_rdata(if_rdata_a), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready_a), .d_rdata(d_rdata_a), .mem_en(mem_en_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .if_stall(if_stall_a), .d_stall(d_stall_a));

  mem_port_arbiter #(.DW(32), .LATENCY(4)) dut_b (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready_b),
    .if_rdata(if_rdata_b), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready_b), .d_rdata(d_rdata_b), .mem_en(mem_en_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .if_stall(if_stall_b), .d_stall(d_stall_b));

  mem_port_arbiter #(.DW(32), .LATENCY(1)) dut_c (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready_c),
    .if_rdata(if_rdata_c), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready_c), .d_rdata(d_rdata_c), .mem_en(mem_en_c),
    .mem_we(mem_we_c), .mem_addr(mem_addr_c), .mem_wdata(mem_wdata_c),
    .mem_rdata(mem_rdata_c), .if_stall(if_stall_c), .d_stall(d_stall_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    int en_cnt;
    int rdy_cnt;
    logic [31:0] pc;
    rst = 1'b1; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    next_cycle();
    do_reset();

    @(negedge clk);
    check("rst_mem_en", {31'd0, mem_en_a}, 32'd0);
    check("rst_if_ready", {31'd0, if_ready_a}, 32'd0);
    check("rst_if_rdata", if_rdata_a, 32'd0);
    check("rst_d_rdata", d_rdata_a, 32'd0);
    check("rst_mem_addr", mem_addr_a, 32'd0);
    next_cycle();

    // fetch only, LATENCY 2
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("f_mem_en_c%0d", c), {31'd0, mem_en_a}, {31'd0, (c == 1 || c == 2)});
      check($sformatf("f_if_ready_c%0d", c), {31'd0, if_ready_a}, {31'd0, (c == 3)});
      check($sformatf("f_if_stall_c%0d", c), {31'd0, if_stall_a}, {31'd0, (c < 3)});
      if (c == 1) check("f_mem_addr", mem_addr_a, 32'h40);
      if (c == 3) check("f_if_rdata", if_rdata_a, 32'h8C01_0004);
      next_cycle();
    end
    if_req = 1'b0;
    idle(8);

    // simultaneous fetch and load after reset
    do_reset();
    if_req = 1'b1; if_addr = 32'h80; d_read = 1'b1; d_addr = 32'h200;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("s_d_ready_c%0d", c), {31'd0, d_ready_a}, {31'd0, (c == 3)});
      check($sformatf("s_if_ready_c%0d", c), {31'd0, if_ready_a}, {31'd0, (c == 7)});
      check($sformatf("s_d_stall_c%0d", c), {31'd0, d_stall_a}, {31'd0, (c < 3)});
      check($sformatf("s_if_stall_c%0d", c), {31'd0, if_stall_a}, {31'd0, (c < 7)});
      check($sformatf("s_mem_en_c%0d", c), {31'd0, mem_en_a},
            {31'd0, (c == 1 || c == 2 || c == 5 || c == 6)});
      if (c == 1) check("s_mem_addr_d", mem_addr_a, 32'h200);
      if (c == 5) check("s_mem_addr_if", mem_addr_a, 32'h80);
      if (c == 3) check("s_d_rdata", d_rdata_a, 32'hA5A5_0200);
      if (c == 7) check("s_if_rdata", if_rdata_a, 32'hA5A5_0080);
      next_cycle();
      if (c == 3) d_read = 1'b0;
      if (c == 7) if_req = 1'b0;
    end
    idle(10);

    // store
    d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("w_mem_we_c%0d", c), {31'd0, mem_we_a}, {31'd0, (c == 1 || c == 2)});
      check($sformatf("w_d_ready_c%0d", c), {31'd0, d_ready_a}, {31'd0, (c == 3)});
      if (c == 1) check("w_mem_wdata", mem_wdata_a, 32'hDEAD_BEEF);
      if (c == 2) check("w_mem_addr", mem_addr_a, 32'h100);
      if (c == 3) check("w_d_rdata_kept", d_rdata_a, 32'hA5A5_0200);
      next_cycle();
    end
    d_write = 1'b0;
    idle(10);

    // read and write together is a write
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) check("rw_mem_we", {31'd0, mem_we_a}, 32'd1);
      if (c == 1) check("rw_mem_wdata", mem_wdata_a, 32'h1234_5678);
      check($sformatf("rw_d_ready_c%0d", c), {31'd0, d_ready_a}, {31'd0, (c == 3)});
      if (c == 3) check("rw_d_rdata_kept", d_rdata_a, 32'hA5A5_0200);
      next_cycle();
    end
    d_read = 1'b0; d_write = 1'b0;
    idle(10);

    // reset mid-BUSY, LATENCY 4
    d_read = 1'b1; d_addr = 32'h300;
    @(negedge clk); next_cycle();
    @(negedge clk);
    check("r_mem_en_busy1", {31'd0, mem_en_b}, 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("r_mem_en_busy2", {31'd0, mem_en_b}, 32'd1);
    next_cycle();
    rst = 1'b0; d_read = 1'b0;
    @(negedge clk);
    check("r_mem_en", {31'd0, mem_en_b}, 32'd0);
    check("r_mem_we", {31'd0, mem_we_b}, 32'd0);
    check("r_mem_addr", mem_addr_b, 32'd0);
    check("r_d_rdata", d_rdata_b, 32'd0);
    check("r_if_rdata", if_rdata_b, 32'd0);
    check("r_d_ready", {31'd0, d_ready_b}, 32'd0);
    rdy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge clk);
      if (d_ready_b) rdy_cnt++;
    end
    check("r_no_ready", rdy_cnt, 32'd0);
    next_cycle();
    idle(4);

    // LATENCY 1, back-to-back fetches
    do_reset();
    pc = 32'h10; if_req = 1'b1; if_addr = pc; en_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("b_if_ready_k%0d", k), {31'd0, if_ready_c}, {31'd0, (k % 3 == 2)});
      check($sformatf("b_mem_en_k%0d", k), {31'd0, mem_en_c}, {31'd0, (k % 3 == 1)});
      if (mem_en_c) begin
        en_cnt++;
        check($sformatf("b_mem_addr_k%0d", k), mem_addr_c, pc);
      end
      if (k % 3 == 2) begin
        check($sformatf("b_if_rdata_k%0d", k), if_rdata_c, mem_model(pc));
        pc = pc + 32'd4;
      end
      next_cycle();
      if_addr = pc;
    end
    if_req = 1'b0;
    check("b_access_count", en_cnt, 32'd3);
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
